// File: rtl/char_pkg.sv
// char_pkg: character classes, recognizer and arbiter state encodings
package char_pkg;
    localparam logic [7:0] DIGIT_LO = 8'd48;
    localparam logic [7:0] DIGIT_HI = 8'd57;
    localparam logic [7:0] UPPER_LO = 8'd65;
    localparam logic [7:0] UPPER_HI = 8'd90;
    localparam logic [7:0] LOWER_LO = 8'd97;
    localparam logic [7:0] LOWER_HI = 8'd122;
    typedef enum logic [1:0] {S0 = 2'b00, S1 = 2'b01, S2 = 2'b10} rs_t;
    // grant encodings double as the one-hot ready vector
    typedef enum logic [1:0] {IDLE = 2'b00, GRANT0 = 2'b01, GRANT1 = 2'b10} arb_t;
    function automatic logic is_digit(input logic [7:0] c);
        return c >= DIGIT_LO && c <= DIGIT_HI;
    endfunction
    function automatic logic is_letter(input logic [7:0] c);
        return (c >= UPPER_LO && c <= UPPER_HI) || (c >= LOWER_LO && c <= LOWER_HI);
    endfunction
endpackage

// File: rtl/id_recog_core.sv
// id_recog_core: letter-run-then-digit recognizer with registered hit
module id_recog_core
    import char_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] char,
    input  logic       clr,
    output logic       hit,
    output logic       new_id
);
    rs_t  rs, rs_n;
    logic dig, ltr;
    // classify the offered character and pick the next recognizer state
    always_comb begin
        dig    = is_digit(char);
        ltr    = is_letter(char);
        new_id = en && rs == S1 && dig;
        rs_n   = !en ? rs : clr ? S0 : ltr ? S1 : (dig && rs != S0) ? S2 : S0;
    end
    // recognizer state and one-cycle hit pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            rs  <= S0;
            hit <= 1'b0;
        end else begin
            rs  <= rs_n;
            hit <= en && dig && rs != S0;
        end
    end
endmodule

// File: rtl/id_scan_arbiter.sv
// id_scan_arbiter: two-source token arbiter feeding one identifier recognizer
module id_scan_arbiter
    import char_pkg::*;
#(
    parameter int MAX_RUN = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       in_valid,
    input  logic [7:0]       in_char0,
    input  logic [7:0]       in_char1,
    output logic [1:0]       in_ready,
    output logic             out_hit,
    output logic             out_src,
    output logic [CNT_W-1:0] id_cnt0,
    output logic [CNT_W-1:0] id_cnt1
);
    arb_t       state, state_n;
    logic       rr, sel, xfer, limit, rel, hit, new_id, src_q, src_hold;
    logic [7:0] run_cnt, ch;
    // character mux, transfer/release detection and next arbiter state
    always_comb begin
        sel     = state == GRANT1;
        ch      = sel ? in_char1 : in_char0;
        xfer    = (state == GRANT0 && in_valid[0]) || (state == GRANT1 && in_valid[1]);
        limit   = xfer && run_cnt == 8'(MAX_RUN - 1);
        rel     = xfer && (limit || !(is_digit(ch) || is_letter(ch)));
        state_n = state != IDLE ? (rel ? IDLE : state) :
                  in_valid == 2'b01 ? GRANT0 :
                  in_valid == 2'b10 ? GRANT1 :
                  in_valid == 2'b11 ? (rr ? GRANT1 : GRANT0) : IDLE;
    end
    assign in_ready = state;
    assign out_hit  = hit;
    assign out_src  = hit ? src_q : src_hold;
    id_recog_core u_core (
        .clk    (clk),
        .reset  (reset),
        .en     (xfer),
        .char   (ch),
        .clr    (limit),
        .hit    (hit),
        .new_id (new_id)
    );
    // arbiter state, round-robin pointer, run length, source tag and id counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rr       <= 1'b0;
            run_cnt  <= 8'd0;
            src_q    <= 1'b0;
            src_hold <= 1'b0;
            id_cnt0  <= '0;
            id_cnt1  <= '0;
        end else begin
            state    <= state_n;
            rr       <= rel ? !sel : rr;
            run_cnt  <= rel ? 8'd0 : xfer ? run_cnt + 8'd1 : run_cnt;
            src_q    <= xfer ? sel : src_q;
            src_hold <= out_src;
            if (new_id && !sel && id_cnt0 != '1) id_cnt0 <= id_cnt0 + CNT_W'(1);
            if (new_id && sel && id_cnt1 != '1) id_cnt1 <= id_cnt1 + CNT_W'(1);
        end
    end
endmodule
